// File: rtl/booth_mul_iter.sv
// ----------------------------------------------------------------------------
// booth_mul_iter
//
// Iterative radix-4 Booth multiplier for MULT / MULTU in the execute stage.
// Each CALC cycle retires one Booth group: the selector picks a partial product
// (0, +-X, +-2X) from the three low multiplier bits. Then the sequencer adds it
// and its two's-complement correction bit into the accumulator. It also shifts
// the multiplicand left and the multiplier right by two. After ITER groups,
// the low 64 bits of the accumulator go to {hi, lo}, and done pulses for one
// cycle.
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   start      new multiply request, sampled only in IDLE
//   signed_op  1 = MULT (signed), 0 = MULTU; sampled with start
//   a          multiplicand; sampled with start
//   b          multiplier; sampled with start
//   flush      abort the operation in flight (CALC only)
//   busy       high while in CALC
//   done       one-cycle pulse; hi/lo are valid in the same cycle
//   hi, lo     64-bit product; held until the next completed operation
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// booth_pp_sel
//
// Radix-4 Booth partial-product selector. Negative multiples are produced as
// the one's complement of the multiple. A correction flag (c[0] for -X, c[1]
// for -2X) tells the accumulator to add the missing +1.
//
// Ports
//   _X   multiplicand, already aligned to the current group's weight
//   src  Booth group {y[2i+1], y[2i], y[2i-1]}
//   p    selected partial product (one's complement when negative)
//   c    correction flags; their OR is the +1 to add alongside p
// ----------------------------------------------------------------------------
module booth_pp_sel #(
    parameter int ACC_W = 68
) (
    input  logic [ACC_W-1:0] _X,
    input  logic [2:0]       src,
    output logic [ACC_W-1:0] p,
    output logic [1:0]       c
);

    // NOTE: every output gets a default at the top of always_comb so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        p = '0;
        c = 2'b00;
        case (src)
            3'b001, 3'b010: p = _X;
            3'b011:         p = _X << 1;
            3'b100: begin
                p = ~(_X << 1);
                c = 2'b10;
            end
            3'b101, 3'b110: begin
                p = ~_X;
                c = 2'b01;
            end
            default: begin
                p = '0;
                c = 2'b00;
            end
        endcase
    end

endmodule

module booth_mul_iter #(
    parameter int ITER  = 17,
    parameter int ACC_W = 68
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int Y_W   = 2 * ITER + 1;
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] x_reg;
    logic [Y_W-1:0]   y_reg;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;

    logic [ACC_W-1:0] pp;
    logic [1:0]       pc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] x_init;
    logic [Y_W-1:0]   y_init;
    logic             ext_b;

    booth_pp_sel #(
        .ACC_W (ACC_W)
    ) u_sel (
        ._X  (x_reg),
        .src (y_reg[2:0]),
        .p   (pp),
        .c   (pc)
    );

    // The Booth groups run over bits 33..32 of the multiplier, so b gets two
    // extension bits. For MULTU these are zero. The top group then sees
    // {0,0,b[31]} and adds +X when b[31] is set, which keeps unsigned operands
    // exact.
    always_comb begin
        ext_b    = signed_op & b[31];
        x_init   = signed_op ? {{(ACC_W-32){a[31]}}, a} : {{(ACC_W-32){1'b0}}, a};
        y_init   = {ext_b, ext_b, b, 1'b0};
        acc_next = acc + pp + {{(ACC_W-1){1'b0}}, pc[1] | pc[0]};
    end

    // NOTE: all state here uses non-blocking assignments, so every register
    // sees the pre-edge value of every other register, as the hardware does.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            x_reg <= '0;
            y_reg <= '0;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // start takes priority over flush; flush means nothing here.
                    if (start) begin
                        x_reg <= x_init;
                        y_reg <= y_init;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end

                CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc   <= acc_next;
                        x_reg <= x_reg << 2;
                        y_reg <= y_reg >> 2;
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            // Commit from acc_next so the result is already
                            // valid during the DONE cycle.
                            hi    <= acc_next[63:32];
                            lo    <= acc_next[31:0];
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_iter.sv
// ----------------------------------------------------------------------------
// tb_booth_mul_iter
//
// Self-checking bench for booth_mul_iter.
// The reference model works at the operation level. The product comes from
// plain 64-bit arithmetic. An op-phase counter gives the 17 busy cycles, then
// one done cycle. A negedge compare process checks busy/done/hi/lo against
// the model every cycle. Directed cases pin the model to literal values, and
// randomized traffic covers start, flush and corner operands.
// ----------------------------------------------------------------------------
module tb_booth_mul_iter;

    logic        clk       = 1'b0;
    logic        resetn    = 1'b0;
    logic        start     = 1'b0;
    logic        signed_op = 1'b0;
    logic        flush     = 1'b0;
    logic [31:0] a         = '0;
    logic [31:0] b         = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    booth_mul_iter dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic sop, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        if (sop) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    // Operation-level model: phase 0 = idle, 1..17 = busy cycles, 18 = done.
    int          m_phase = 0;
    logic [63:0] m_prod  = '0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_phase = 0;
            m_prod  = '0;
            m_hi    = '0;
            m_lo    = '0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_prod  = ref_prod(signed_op, a, b);
                m_phase = 1;
            end
        end else if (m_phase == 18) begin
            m_phase = 0;
        end else if (flush) begin
            m_phase = 0;
        end else if (m_phase == 17) begin
            {m_hi, m_lo} = m_prod;
            m_phase      = 18;
        end else begin
            m_phase++;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", 64'(busy), 64'(m_phase >= 1 && m_phase <= 17));
            check("done", 64'(done), 64'(m_phase == 18));
            check("hi",   64'(hi),   64'(m_hi));
            check("lo",   64'(lo),   64'(m_lo));
        end
    end

    // Waits for done after the start-clearing negedge (lat = 1 there).
    task automatic wait_done(inout int lat, output int bcnt);
        bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) check("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic run_mul(input logic sop, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] rhi, output logic [31:0] rlo,
                           output int lat, output int bcnt);
        @(negedge clk);
        signed_op = sop;
        a         = x;
        b         = y;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        wait_done(lat, bcnt);
        rhi = hi;
        rlo = lo;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin : stim
        logic [31:0] rh;
        logic [31:0] rl;
        int          lat;
        int          bc;
        bit          saw_done;

        // Model pinned to hand-computed products.
        check("ref_s_m1xm1",   ref_prod(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'h0000_0000_0000_0001);
        check("ref_u_maxsq",   ref_prod(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        check("ref_s_minsq",   ref_prod(1'b1, 32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);
        check("ref_s_7xm3",    ref_prod(1'b1, 32'd7, 32'hFFFF_FFFD),         64'hFFFF_FFFF_FFFF_FFEB);
        check("ref_u_big",     ref_prod(1'b0, 32'h1234_5678, 32'h9ABC_DEF0), 64'h0B00_EA4E_242D_2080);

        // Reset state.
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Signed -1 * -1: latency and busy width.
        run_mul(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, lat, bc);
        check("lat_s_m1", 64'(lat), 64'd18);
        check("busy_cycles", 64'(bc), 64'd17);
        check("res_s_m1", {rh, rl}, 64'h0000_0000_0000_0001);

        run_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, lat, bc);
        check("res_u_maxsq", {rh, rl}, 64'hFFFF_FFFE_0000_0001);

        run_mul(1'b1, 32'h8000_0000, 32'h8000_0000, rh, rl, lat, bc);
        check("res_s_minsq", {rh, rl}, 64'h4000_0000_0000_0000);

        run_mul(1'b1, 32'd7, 32'hFFFF_FFFD, rh, rl, lat, bc);
        check("res_s_7xm3", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFEB);

        // Start during CALC is ignored.
        @(negedge clk);
        signed_op = 1'b0;
        a         = 32'd7;
        b         = 32'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_at_cnt4", 64'(busy), 64'd1);
        a     = 32'd5;
        b     = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 6;
        wait_done(lat, bc);
        check("lat_ignored_start", 64'(lat), 64'd18);
        check("res_7x3", {hi, lo}, 64'd21);

        // Restart in the cycle right after DONE.
        run_mul(1'b0, 32'd2, 32'd2, rh, rl, lat, bc);
        check("lat_back_to_back", 64'(lat), 64'd18);
        check("res_2x2", {rh, rl}, 64'd4);

        // Flush at count 9.
        run_mul(1'b0, 32'd2, 32'd3, rh, rl, lat, bc);
        check("res_2x3", {rh, rl}, 64'd6);
        @(negedge clk);
        a     = 32'd100;
        b     = 32'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_low", 64'(busy), 64'd0);
        saw_done = 1'b0;
        repeat (25) begin
            saw_done |= done;
            @(negedge clk);
        end
        check("flush_no_done", 64'(saw_done), 64'd0);
        check("flush_lo_held", {hi, lo}, 64'd6);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        a     = 32'h1234_5678;
        b     = 32'h9ABC_DEF0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_mul(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, rh, rl, lat, bc);
        check("lat_after_rst", 64'(lat), 64'd18);
        check("res_u_big", {rh, rl}, 64'h0B00_EA4E_242D_2080);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 3) == 0);
            signed_op = $urandom_range(0, 1);
            a         = pick_operand();
            b         = pick_operand();
            flush     = ($urandom_range(0, 24) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        repeat (25) @(negedge clk);
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mul_iter.md
Name: booth_mul_iter

Overview:
- Iterative radix-4 Booth multiplier sequencer for MULT/MULTU in the execute stage.
- Consumes the 68-bit partial product and 2-bit correction produced by the team's Booth partial-product selector (ports _X[67:0], src[2:0] in; p[67:0], c[1:0] out), which it instantiates.
- Accumulates one partial product per cycle and hands a 64-bit {hi,lo} result to the HI/LO write logic through a start/done handshake.

Parameters:
- ITER, 17, number of Booth groups; fixed by the 34-bit extended multiplier.
- ACC_W, 68, width of the accumulator and multiplicand datapath.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous, active-low reset
- start  input  1  request a new multiply; sampled only in IDLE
- signed_op  input  1  1 = MULT (signed), 0 = MULTU; sampled with start
- a  input  32  multiplicand; sampled with start
- b  input  32  multiplier; sampled with start
- flush  input  1  abort the in-flight operation (pipeline exception)
- busy  output  1  high in CALC
- done  output  1  one-cycle pulse when result becomes valid
- hi  output  32  result[63:32]
- lo  output  32  result[31:0]

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; busy=0, done=0, hi=0, lo=0; accumulator, X and Y registers cleared.
- States: IDLE, CALC, DONE.
- IDLE, start=1:
  - X <= a extended to 68 bits (sign-extended if signed_op, else zero-extended).
  - Y <= {e,e,b,1'b0}, 35 bits, where e = signed_op & b[31].
  - acc <= 0; count <= 0; next state CALC.
- CALC, each cycle:
  - src = Y[2:0] drives the selector; _X = X.
  - acc <= acc + p + {67'b0, c[1]|c[0]}, modulo 2^68.
  - X <= X << 2; Y <= Y >> 2 (logical); count <= count + 1.
  - After the cycle with count == ITER-1, next state DONE.
- DONE, single cycle:
  - done=1; hi/lo are loaded from acc[63:0] on the CALC->DONE edge and are already valid.
  - Next state IDLE.
- hi/lo hold their value until the next completed operation. Flush and new starts do not alter them until a new DONE.
- Latency: start sampled at edge 0 -> done high during cycle 18, i.e. 18 clocks after the start edge. Throughput: one multiply per 19 cycles; start may be reasserted in the cycle after DONE.
- start in CALC or DONE is ignored, with no queueing. The driver must hold start only while busy=0.
- flush=1 in CALC: next state IDLE, busy drops next cycle, no done pulse, hi/lo unchanged.
- flush=1 in IDLE or DONE: no effect; the DONE-cycle result is still committed.
- flush and start both high in IDLE: start wins.
- Arithmetic: the result is exact for all operand values. acc[67:64] is discarded. Unsigned 0xFFFFFFFF is handled by the zero-extended top Booth group (count 16).
- Reset asserted mid-operation: immediately returns to the reset values above; no done pulse.

Test Plan:
- signed_op=1, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 18 clocks done=1, hi=0x00000000, lo=0x00000001; busy high exactly 17 cycles.
- signed_op=0, a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- signed_op=1, a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000. Then a=7, b=0xFFFFFFFD (-3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Start 7*3 unsigned; pulse start with a=5, b=5 at count 4 -> second start ignored, result hi=0, lo=21. Start accepted again in the cycle after done.
- Complete 2*3 (lo=6), start 100*100, assert flush at count 9 -> no done pulse, busy low next cycle, lo stays 6.
- Deassert resetn mid-CALC -> busy, done, hi and lo all 0 asynchronously. Release and run 0x12345678*0x9ABCDEF0 unsigned -> hi=0x0B00EA4E, lo=0x242D2080.
